seg7_scan_decoder: RTL

//  Receive side of the multiplexed 7-segment display bus (seg/sel) driven by the scan driver.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_scan_decoder_pattern_decode.sv | 11 +
 rtl/seg7_scan_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table, special codes and dwell FSM state type.
package seg7_pkg;

  // Segment patterns {a,b,c,d,e,f,g}, bit6 = a, active-high.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_MINUS = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_MINUS   = 4'hA;
  localparam logic [3:0] CODE_INVALID = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} dwell_state_e;

  // Inverse of the scan driver's table; anything unrecognised is flagged invalid.
  function automatic logic [3:0] seg_to_code(input logic [6:0] seg);
    case (seg)
      SEG_0:     return 4'd0;
      SEG_1:     return 4'd1;
      SEG_2:     return 4'd2;
      SEG_3:     return 4'd3;
      SEG_4:     return 4'd4;
      SEG_5:     return 4'd5;
      SEG_6:     return 4'd6;
      SEG_7:     return 4'd7;
      SEG_8:     return 4'd8;
      SEG_9:     return 4'd9;
      SEG_MINUS: return CODE_MINUS;
      SEG_BLANK: return CODE_BLANK;
      default:   return CODE_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit code decoder.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  assign code = seg_to_code(seg);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: syncs seg/sel, waits for each
// digit dwell to settle, decodes it and assembles complete scans into frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2**26
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [6:0]              seg_in,
  input  logic [7:0]              sel_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    sel_err,
  output logic                    stale
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE_CYCLES);
  localparam logic [ToW-1:0]  ToMax     = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      SelMask   = 8'((1 << NUM_DIGITS) - 1);

  logic [6:0] seg_m, seg_s, seg_p;
  logic [7:0] sel_m, sel_s, sel_p;
  logic [CntW-1:0] stab_cnt_q, cnt_now;
  logic [ToW-1:0]  to_cnt_q;
  dwell_state_e    state_q;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_next;
  logic [NUM_DIGITS-1:0]   seen_q, seen_next, cap_bit;
  logic [3:0] code;
  logic changed, sel_blank, sel_legal, sel_illegal, capture, frame_done, any_invalid;

  seg7_pattern_decode u_decode (
    .seg  (seg_s),
    .code (code)
  );

  // Two-flop synchronizers plus the previous synced sample for change detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_m <= '0;
      seg_s <= '0;
      seg_p <= '0;
      sel_m <= '0;
      sel_s <= '0;
      sel_p <= '0;
    end else begin
      seg_m <= seg_in;
      seg_s <= seg_m;
      seg_p <= seg_s;
      sel_m <= sel_in;
      sel_s <= sel_m;
      sel_p <= sel_s;
    end
  end

  // Classify the synced select and count how long the current sample has been stable.
  always_comb begin
    changed     = {sel_s, seg_s} != {sel_p, seg_p};
    sel_blank   = sel_s == '0;
    sel_legal   = !sel_blank && ((sel_s & ~SelMask) == '0) && $onehot(sel_s);
    sel_illegal = !sel_blank && !sel_legal;
    cap_bit     = sel_s[NUM_DIGITS-1:0];
    cnt_now     = stab_cnt_q;
    if (changed) begin
      cnt_now = CntW'(1);
    end else if (stab_cnt_q != SettleMax) begin
      cnt_now = stab_cnt_q + 1'b1;
    end
    // The stable count includes the current sample, so capture happens on the
    // SETTLE_CYCLES-th identical sample. HOLD blocks recapture of the same dwell.
    capture    = sel_legal && (changed || state_q != HOLD) && (cnt_now == SettleMax);
    seen_next  = seen_q | cap_bit;
    frame_done = capture && (&seen_next);
  end

  // Merge the newly decoded nibble so a completing frame carries it in the same edge.
  always_comb begin
    shadow_next = shadow_q;
    any_invalid = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (cap_bit[i]) shadow_next[4*i +: 4] = code;
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (shadow_next[4*i +: 4] == CODE_INVALID) any_invalid = 1'b1;
    end
  end

  // Dwell FSM with registered sel_err pulse on each entry into an illegal select.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
      sel_err    <= 1'b0;
    end else begin
      stab_cnt_q <= cnt_now;
      sel_err    <= sel_illegal && changed;
      if (!sel_legal) begin
        state_q <= IDLE;
      end else if (capture) begin
        state_q <= HOLD;
      end else if (changed || state_q == IDLE) begin
        state_q <= SETTLE;
      end
    end
  end

  // Shadow/seen bookkeeping and frame publication.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q    <= '0;
      seen_q      <= '0;
      digits_out  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (capture) begin
        shadow_q <= shadow_next;
        seen_q   <= frame_done ? '0 : seen_next;
      end
      if (frame_done) begin
        digits_out <= shadow_next;
        frame_err  <= any_invalid;
      end
    end
  end

  // Staleness timer; a completing frame takes priority over the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
      stale    <= 1'b0;
    end else if (frame_done) begin
      to_cnt_q <= '0;
      stale    <= 1'b0;
    end else begin
      if (to_cnt_q != ToMax) to_cnt_q <= to_cnt_q + 1'b1;
      if (to_cnt_q == ToMax) stale <= 1'b1;
    end
  end

endmodule
